// File: rtl/task_3_out.sv
// Purpose : captures one NUM_WORDS frame from the upstream FIFO read port, then replays it as an AXI-Stream master.
// Latency : first beat valid 1 cycle after the last word is written; o_output_last 1 cycle after the final beat.
// Backpr. : i_tready stalls hold o_tdata/o_tlast/o_tvalid; words arriving outside IDLE/COLLECT are dropped (sticky overflow).
module task_3_out #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 243,
  parameter int CNT_WIDTH  = $clog2(NUM_WORDS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enb,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  output logic                  o_output_last,
  output logic                  o_busy,
  output logic                  o_overflow
);

  // Buffer address width; counters carry one extra value (NUM_WORDS) so they can saturate.
  localparam int ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] LP_FULL = CNT_WIDTH'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SEND    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  w_rd_nxt;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_en;
  logic                  w_beat;
  logic                  w_ovf_hit;

  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_output_last;
  logic                  r_busy;
  logic                  r_overflow;

  // Frame storage; contents are don't-care after reset, so no reset branch.
  logic [DATA_WIDTH-1:0] r_buf [NUM_WORDS];

  // IDLE always writes slot 0 (first word of a new frame); COLLECT writes at the running count.
  assign w_wr_addr = (r_state == S_IDLE) ? '0 : r_wr_cnt[ADDR_W-1:0];
  assign w_rd_nxt  = r_rd_cnt + 1'b1;
  // Prefetch of the next beat's word; only consumed when the current beat is not the last.
  assign w_rd_data = r_buf[w_rd_nxt[ADDR_W-1:0]];

  // Buffer write port.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_addr] <= i_data;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, buffer write enable and overflow detection.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_beat      = r_tvalid & i_tready;
    w_ovf_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enb) begin
          w_wr_en     = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_enb) begin
          w_wr_en = (r_wr_cnt != LP_FULL);
          if (r_wr_cnt == LP_LAST) begin
            w_state_nxt = S_SEND;
          end
        end
      end
      S_SEND: begin
        w_ovf_hit = i_enb;
        if (w_beat && (r_rd_cnt == LP_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_ovf_hit   = i_enb;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters and registered stream outputs; beat registers only move on a handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_output_last <= 1'b0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_busy        <= (w_state_nxt != S_IDLE);
      r_output_last <= 1'b0;
      if (w_ovf_hit) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_rd_cnt <= '0;
          if (i_enb) begin
            r_wr_cnt <= CNT_WIDTH'(1);
          end
        end
        S_COLLECT: begin
          if (i_enb) begin
            if (r_wr_cnt != LP_FULL) begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            // Final word: present beat 0 on the very next cycle (slot 0 was written long ago).
            if (r_wr_cnt == LP_LAST) begin
              r_rd_cnt <= '0;
              r_tvalid <= 1'b1;
              r_tdata  <= r_buf[0];
              r_tlast  <= 1'b0;
            end
          end
        end
        S_SEND: begin
          if (w_beat) begin
            if (r_rd_cnt == LP_LAST) begin
              r_tvalid      <= 1'b0;
              r_tlast       <= 1'b0;
              r_output_last <= 1'b1;
            end else begin
              r_rd_cnt <= w_rd_nxt;
              r_tdata  <= w_rd_data;
              r_tlast  <= (w_rd_nxt == LP_LAST);
            end
          end
        end
        S_DONE: begin
          r_wr_cnt <= '0;
          r_rd_cnt <= '0;
        end
        default: begin
          r_wr_cnt <= '0;
        end
      endcase
    end
  end

  assign o_tdata       = r_tdata;
  assign o_tvalid      = r_tvalid;
  assign o_tlast       = r_tlast;
  assign o_output_last = r_output_last;
  assign o_busy        = r_busy;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_task_3_out.sv
// Purpose : scoreboard bench for task_3_out; stimulus pushes expected beats, a monitor pops and compares.
// Latency : checks first beat 1 cycle after last word and o_output_last 1 cycle after the final beat.
// Backpr. : drives i_tready patterns and checks output stability during every stall.
module tb_task_3_out;

  localparam int DW = 8;
  localparam int NW = 243;

  logic          i_clk;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic          i_enb;
  logic          i_tready;
  logic [DW-1:0] o_tdata;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_output_last;
  logic          o_busy;
  logic          o_overflow;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ol    = 0;
  int   tr_mode = 0;
  int   tr_cyc  = 0;
  logic early_vld;

  task_3_out #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_enb        (i_enb),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tvalid     (o_tvalid),
    .o_tlast      (o_tlast),
    .o_output_last(o_output_last),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_word(input int pat, input int idx);
    logic [DW-1:0] b;
    b = idx[DW-1:0];
    case (pat)
      0:       return b;
      1:       return 8'hA5 ^ b;
      2:       return ~b;
      default: return 8'(idx * 3 + 1);
    endcase
  endfunction

  // i_tready driver: always high, or the repeating 1,0,0,1 pattern.
  initial begin
    i_tready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      tr_cyc++;
      if (tr_mode != 0) i_tready = ((tr_cyc % 4) == 0) || ((tr_cyc % 4) == 3);
      else              i_tready = 1'b1;
    end
  end

  // Monitor: pops expected beats on each handshake, checks stall stability and the output_last pulse.
  initial begin
    logic          stall_pend;
    logic          ol_pend;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    exp_t          e;
    stall_pend = 1'b0;
    ol_pend    = 1'b0;
    hold_d     = '0;
    hold_l     = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        stall_pend = 1'b0;
        ol_pend    = 1'b0;
      end else begin
        if (ol_pend) begin
          check("output_last_pulse", o_output_last, 1);
          if (o_output_last) n_ol++;
          ol_pend = 1'b0;
        end else if (o_output_last) begin
          check("output_last_spurious", o_output_last, 0);
        end
        if (stall_pend) begin
          check("stall_valid", o_tvalid, 1);
          check("stall_data", o_tdata, hold_d);
          check("stall_last", o_tlast, hold_l);
        end
        stall_pend = o_tvalid && !i_tready;
        hold_d     = o_tdata;
        hold_l     = o_tlast;
        if (o_tvalid && i_tready) begin
          if (q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            e = q.pop_front();
            check("beat_data", o_tdata, e.d);
            check("beat_last", o_tlast, e.l);
            ol_pend = e.l;
          end
        end
      end
    end
  end

  // Drives words start..NW-1 of a frame; caller is at posedge+1. Returns at posedge+1 after the last capture.
  task automatic send_frame(input int pat, input int gap, input int start);
    early_vld = 1'b0;
    for (int i = start; i < NW; i++) begin
      if (o_tvalid) early_vld = 1'b1;
      i_enb  = 1'b1;
      i_data = pat_word(pat, i);
      q.push_back(exp_t'{d: pat_word(pat, i), l: (i == NW - 1)});
      @(posedge i_clk);
      #1;
      i_enb = 1'b0;
      if (i != NW - 1) begin
        repeat (gap) begin
          @(posedge i_clk);
          #1;
          if (o_tvalid) early_vld = 1'b1;
        end
      end
    end
    check("collect_no_valid", early_vld, 0);
    check("first_beat_latency", o_tvalid, 1);
  endtask

  task automatic wait_ol(input int target);
    for (int k = 0; k < 3000 && n_ol < target; k++) begin
      @(posedge i_clk);
      #2;
    end
    check("frame_done", (n_ol >= target), 1);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int ol_before;
    int found;
    i_rst_n = 1'b0;
    i_enb   = 1'b0;
    i_data  = '0;

    // Power-on reset values.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_output_last", o_output_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_tdata", o_tdata, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Full frame, ready always high.
    send_frame(0, 0, 0);
    wait_ol(1);

    // Backpressure pattern 1,0,0,1.
    tr_mode = 1;
    @(posedge i_clk);
    #1;
    send_frame(0, 0, 0);
    wait_ol(2);
    tr_mode = 0;

    // Gapped input, one word every 3rd cycle.
    @(posedge i_clk);
    #1;
    send_frame(1, 2, 0);
    wait_ol(3);

    // Asynchronous reset in the middle of the send phase.
    @(posedge i_clk);
    #1;
    send_frame(0, 0, 0);
    repeat (20) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("midrst_tvalid", o_tvalid, 0);
    check("midrst_tlast", o_tlast, 0);
    check("midrst_output_last", o_output_last, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_tdata", o_tdata, 0);
    ol_before = n_ol;
    repeat (3) @(posedge i_clk);
    q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    check("midrst_no_output_last", n_ol, ol_before);
    check("midrst_idle_busy", o_busy, 0);
    check("midrst_idle_tvalid", o_tvalid, 0);

    // Overflow: stray word around beat 10 of the send phase.
    check("ovf_clear", o_overflow, 0);
    send_frame(2, 0, 0);
    repeat (9) @(posedge i_clk);
    #1;
    i_enb  = 1'b1;
    i_data = 8'hFF;
    @(posedge i_clk);
    #1;
    i_enb = 1'b0;
    check("ovf_set", o_overflow, 1);
    wait_ol(ol_before + 1);
    check("ovf_sticky", o_overflow, 1);

    // Back-to-back frames: frame B's first word on the cycle after o_output_last.
    @(posedge i_clk);
    #1;
    send_frame(3, 0, 0);
    found = 0;
    for (int k = 0; k < 3000 && found == 0; k++) begin
      @(posedge i_clk);
      #2;
      if (o_output_last) found = 1;
    end
    check("b2b_output_last_seen", found, 1);
    check("b2b_busy_done", o_busy, 1);
    @(posedge i_clk);
    #1;
    check("b2b_busy_gap", o_busy, 0);
    i_enb  = 1'b1;
    i_data = pat_word(0, 0);
    q.push_back(exp_t'{d: pat_word(0, 0), l: 1'b0});
    @(posedge i_clk);
    #1;
    i_enb = 1'b0;
    check("b2b_busy_resume", o_busy, 1);
    send_frame(0, 0, 1);
    wait_ol(ol_before + 3);
    check("b2b_ovf_sticky", o_overflow, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
